// File: rtl/dec_stage1.sv
// De-whitening stage: 2-entry {last,data} buffer plus frame word counter with length check.
// One cycle from accept to valid_out when empty; ready_out is registered and drops when the buffer is full.
module dec_stage1 #(
  parameter logic [15:0] WHITEN_KEY = 16'hAAAA,
  parameter logic [7:0]  MAX_WORDS  = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        ready_out,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [7:0]  word_cnt,
  output logic        frame_done,
  output logic        err_len
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BODY = 1'b1;

  logic [16:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]  occ_q, occ_d, occ_pop;
  logic        rdy_q;
  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept, issue;
  logic [16:0] new_ent;

  assign accept  = valid_in && rdy_q;
  assign issue   = (occ_q != 2'd0) && ready_in;
  assign new_ent = {in_last, in_data ^ WHITEN_KEY};

  // ent0 is always the head; a pop shifts ent1 forward before the push lands.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    occ_pop = occ_q - {1'b0, issue};
    if (issue) begin
      ent0_d = ent1_q;
    end
    if (accept) begin
      if (occ_pop == 2'd0) begin
        ent0_d = new_ent;
      end else begin
        ent1_d = new_ent;
      end
    end
    occ_d = occ_pop + {1'b0, accept};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    if (accept) begin
      if (in_last) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        done_d  = 1'b1;
      end else if (cnt_q == MAX_WORDS - 8'd1) begin
        // Overlong frame: flag it, restart the count, still forward the word.
        state_d = IDLE;
        cnt_d   = 8'd0;
        err_d   = 1'b1;
      end else begin
        state_d = BODY;
        cnt_d   = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= 17'd0;
      ent1_q  <= 17'd0;
      occ_q   <= 2'd0;
      rdy_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      occ_q   <= occ_d;
      rdy_q   <= (occ_d < 2'd2);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign valid_out  = (occ_q != 2'd0);
  assign out_data   = valid_out ? ent0_q[15:0] : 16'h0000;
  assign out_last   = valid_out && ent0_q[16];
  assign ready_out  = rdy_q;
  assign word_cnt   = cnt_q;
  assign frame_done = done_q;
  assign err_len    = err_q;

endmodule

// File: doc/dec_stage1.md
DEC_STAGE1 -- requirements
Module: dec_stage1

Interface
REQ-001 SHALL have parameter WHITEN_KEY, default 16'hAAAA: whitening constant removed from each word.
REQ-002 SHALL have parameter MAX_WORDS, default 8'd64: maximum legal words per frame, range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  upstream word present.
REQ-006 SHALL have port in_data  input  16  whitened ciphertext word.
REQ-007 SHALL have port in_last  input  1  word is the final word of its frame; qualified by valid_in.
REQ-008 SHALL have port ready_out  output  1  block can accept a word this cycle.
REQ-009 SHALL have port out_data  output  16  de-whitened word at buffer head.
REQ-010 SHALL have port out_last  output  1  in_last flag of the head word.
REQ-011 SHALL have port valid_out  output  1  head word present.
REQ-012 SHALL have port ready_in  input  1  downstream accepts the head word.
REQ-013 SHALL have port word_cnt  output  8  words accepted so far in the current frame.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after a frame's last word is accepted.
REQ-015 SHALL have port err_len  output  1  sticky frame-length violation flag.

Function
REQ-016 SHALL define accept as valid_in && ready_out, and issue as valid_out && ready_in, both sampled at the same rising edge.
REQ-017 SHALL hold a 2-entry FIFO of {last, data}, with occupancy occ in 0..2; the stored data SHALL be in_data ^ WHITEN_KEY.
REQ-018 SHALL drive valid_out = (occ != 0), with out_data and out_last taken from the head entry; out_data SHALL be 16'h0000 when occ == 0.
REQ-019 SHALL make ready_out a register whose next value is (next_occ < 2).
REQ-020 SHALL present a word accepted at edge N as valid_out after edge N when occ was 0 (latency 1 cycle).
REQ-021 SHALL update occupancy as follows when accept and issue occur at the same edge: occ 1 stays 1, occ 0 goes to 1, occ 2 cannot accept.
REQ-022 SHALL hold head data and valid_out stable while valid_out && !ready_in.
REQ-023 SHALL never drop, duplicate or reorder a word, and SHALL preserve in_last alignment through the FIFO.
REQ-024 SHALL run a frame FSM with states IDLE (word_cnt == 0) and BODY.
REQ-025 SHALL transition IDLE->BODY on accept with in_last = 0, and SHALL stay in IDLE on accept with in_last = 1.
REQ-026 SHALL transition BODY->IDLE on accept with in_last = 1.
REQ-027 SHALL increment word_cnt by 1 on each accept with in_last = 0, and SHALL clear it to 0 on accept with in_last = 1.
REQ-028 SHALL set frame_done = 1 for exactly the cycle following an accept with in_last = 1, and 0 otherwise.
REQ-029 SHALL, on an accept with in_last = 0 while word_cnt == MAX_WORDS-1, set err_len to 1, clear word_cnt to 0, return to IDLE, and pass the word through unchanged.
REQ-030 SHALL keep err_len at 1 until reset once set.
REQ-031 SHALL ignore in_data and in_last whenever valid_in = 0 or ready_out = 0.

Reset
REQ-032 SHALL, while rst = 1, force occ = 0, the FSM to IDLE, and all outputs to 0: ready_out, valid_out, out_data, out_last, word_cnt, frame_done and err_len.
REQ-033 SHALL set ready_out = 1 at the first rising edge after rst deasserts.
REQ-034 SHALL discard buffered words and the partial frame count when reset is asserted mid-operation, with no output pulse.

Verification
REQ-035 SHALL pass this data-path check: single word in_data = 16'h1234, in_last = 1, ready_in = 1 -> next cycle valid_out = 1, out_data = 16'hB89E, out_last = 1, frame_done = 1, word_cnt = 0.
REQ-036 SHALL pass this key-boundary check: in_data = 16'hAAAA -> out_data = 16'h0000; in_data = 16'h5555 -> out_data = 16'hFFFF.
REQ-037 SHALL pass this backpressure check: ready_in = 0, three consecutive valid words -> first two accepted, ready_out = 0 after the second, third held; raising ready_in delivers all three in order.
REQ-038 SHALL pass this streaming check: valid_in = ready_in = 1 continuously for 10 words -> one word issued per cycle, occ stays 1, ready_out stays 1.
REQ-039 SHALL pass this frame-length check: MAX_WORDS = 4, five words with in_last = 0 -> err_len = 1 after the fourth accept, word_cnt = 0 and then 1, all five words output.
REQ-040 SHALL pass this reset check: rst asserted with occ = 2 and word_cnt = 3 -> all outputs 0 immediately, ready_out = 1 one edge after release, no stale word emitted.
